// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer_if
// Description : Handshake bundle for stream_packer. Carries the narrow input
//               beat stream (valid/ready/data) and the wide output word stream
//               (valid/ready/data/keep). Signal names are from the packer's
//               point of view: i_* flow into the packer, o_* flow out of it.
// Modports    : slave  - packer side (consumes beats, produces words)
//               master - environment side (produces beats, consumes words)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
);
  logic                          i_valid;  // input beat valid
  logic                          o_ready;  // packer can take a beat
  logic [DATA_WIDTH-1:0]         i_data;   // input beat
  logic                          o_valid;  // output word valid
  logic                          i_ready;  // downstream can take a word
  logic [DATA_WIDTH*RATIO-1:0]   o_data;   // packed word, first beat in lane 0
  logic [RATIO-1:0]              o_keep;   // 1 = lane holds a real beat

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_keep
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_keep
  );
endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_packer
// Description : Packs RATIO narrow beats into one wide word with a per-lane
//               keep mask. A partially filled word is flushed after TIMEOUT
//               idle cycles (TIMEOUT = 0 disables flushing). The output word
//               sits in a register and holds steady under backpressure.
// Ports       : i_clk - clock, rising edge
//               i_rst - reset, asynchronous assert, active-low
//               bus   - stream_packer_if.slave (input beats, output words)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int TIMEOUT    = 16
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  stream_packer_if.slave   bus
);

  localparam int W      = DATA_WIDTH * RATIO;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  // A zero TIMEOUT would give a zero-width counter; keep one bit instead.
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]  C_LAST     = CNT_W'(RATIO - 1);
  localparam logic [IDLE_W-1:0] C_TMO      = IDLE_W'(TIMEOUT);
  localparam bit                C_FLUSH_EN = (TIMEOUT != 0);

  logic [W-1:0]      acc_q,       acc_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [IDLE_W-1:0] idle_q,      idle_d;
  logic [W-1:0]      out_data_q,  out_data_d;
  logic [RATIO-1:0]  out_keep_q,  out_keep_d;
  logic              out_valid_q, out_valid_d;

  logic              w_out_free;
  logic              w_ready;
  logic              w_accept;
  logic              w_flush;
  logic [RATIO-1:0]  w_flush_keep;

  // The output register can take a new word if it is empty or draining now.
  assign w_out_free = !out_valid_q || bus.i_ready;

  // Only the completing beat needs room in the output register, so the
  // first RATIO-1 beats of a word are taken even under backpressure.
  // Gating with i_rst keeps the handshake closed while reset is held.
  assign w_ready  = i_rst && ((cnt_q != C_LAST) || w_out_free);
  assign w_accept = bus.i_valid && w_ready;

  // An arriving beat always beats a flush in the same cycle.
  assign w_flush = C_FLUSH_EN && (cnt_q != '0) && (idle_q == C_TMO) &&
                   w_out_free && !w_accept;

  always_comb begin
    w_flush_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_flush_keep[i] = (i < int'(cnt_q));
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.i_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      idle_d = '0;
      if (cnt_q == C_LAST) begin
        out_data_d                             = acc_q;
        out_data_d[W-DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
        out_keep_d                             = '1;
        out_valid_d                            = 1'b1;
        acc_d                                  = '0;
        cnt_d                                  = '0;
      end else begin
        acc_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
        cnt_d                                       = cnt_q + CNT_W'(1);
      end
    end else if (w_flush) begin
      out_data_d  = acc_q;
      out_keep_d  = w_flush_keep;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      idle_d      = '0;
    end else if (C_FLUSH_EN && (cnt_q != '0) && (idle_q != C_TMO)) begin
      // Saturates at TIMEOUT; a blocked flush then waits for out_free.
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_keep  = out_keep_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packer
// Description : Scoreboard bench for stream_packer (DATA_WIDTH=8, RATIO=4,
//               TIMEOUT=16). Stimulus pushes expected words; a monitor on the
//               falling edge pops and compares each word transfer and checks
//               that a stalled word holds steady.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  stream_packer_if #(.DATA_WIDTH(8), .RATIO(4)) bus();

  stream_packer #(
    .DATA_WIDTH(8),
    .RATIO     (4),
    .TIMEOUT   (16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    e.d = d;
    e.k = k;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled mid-cycle; a transfer happens on the next rising edge.
  logic        hold_v;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;
  initial hold_v = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (hold_v && rst_n) begin
      chk("stall_valid", {63'd0, bus.o_valid}, 64'd1);
      chk("stall_data",  {32'd0, bus.o_data}, {32'd0, hold_d});
      chk("stall_keep",  {60'd0, bus.o_keep}, {60'd0, hold_k});
    end
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {32'd0, bus.o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", {32'd0, bus.o_data}, {32'd0, e.d});
        chk("word_keep", {60'd0, bus.o_keep}, {60'd0, e.k});
      end
    end
    hold_v = rst_n && bus.o_valid && !bus.i_ready;
    hold_d = bus.o_data;
    hold_k = bus.o_keep;
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d);
    logic a;
    int   g;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    g = 0;
    a = 1'b0;
    while (!a && g < 200) begin
      @(negedge clk);
      a = bus.o_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!a) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic a;
    int   nacc;
    int   k;
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("rst_ready", {63'd0, bus.o_ready}, 64'd0);
    chk("rst_data",  {32'd0, bus.o_data}, 64'd0);
    chk("rst_keep",  {60'd0, bus.o_keep}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, bus.o_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Streaming: two words back to back
    push(32'h44332211, 4'hF);
    push(32'h88776655, 4'hF);
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 8'((i + 1) * 8'h11);
      @(negedge clk);
      chk("stream_ready", {63'd0, bus.o_ready}, 64'd1);
      if (i == 4) begin
        chk("stream_w0_valid", {63'd0, bus.o_valid}, 64'd1);
        chk("stream_w0_data",  {32'd0, bus.o_data}, 64'h44332211);
      end
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("stream_w1_valid", {63'd0, bus.o_valid}, 64'd1);
    chk("stream_w1_data",  {32'd0, bus.o_data}, 64'h88776655);
    wait_drain();

    // Backpressure: 12 beats offered, output stalled
    push(32'h04030201, 4'hF);
    push(32'h08070605, 4'hF);
    push(32'h0C0B0A09, 4'hF);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'd1;
    nacc = 0;
    repeat (20) begin
      @(negedge clk);
      a = bus.o_ready;
      @(posedge clk);
      #1;
      if (a) begin
        nacc++;
        bus.i_data = 8'(nacc + 1);
      end
    end
    chk("bp_accepted", 64'(nacc), 64'd7);
    @(negedge clk);
    chk("bp_ready_low", {63'd0, bus.o_ready}, 64'd0);
    chk("bp_held_data", {32'd0, bus.o_data}, 64'h04030201);
    @(posedge clk);
    #1;
    bus.i_ready = 1'b1;
    k = 0;
    while (nacc < 12 && k < 100) begin
      @(negedge clk);
      a = bus.o_ready;
      @(posedge clk);
      #1;
      k++;
      if (a) begin
        nacc++;
        bus.i_data = 8'(nacc + 1);
      end
    end
    bus.i_valid = 1'b0;
    chk("bp_total", 64'(nacc), 64'd12);
    wait_drain();

    // Timeout flush: valid exactly 17 cycles after the last handshake
    push(32'h0000BBAA, 4'h3);
    send(8'hAA);
    send(8'hBB);
    bus.i_valid = 1'b0;
    k = 0;
    while (!bus.o_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("flush_latency", 64'(k), 64'd17);
    chk("flush_data", {32'd0, bus.o_data}, 64'h0000BBAA);
    chk("flush_keep", {60'd0, bus.o_keep}, 64'h3);
    wait_drain();

    // Flush vs arrival: beat offered as idle reaches its limit wins
    push(32'hDDCCBBAA, 4'hF);
    send(8'hAA);
    send(8'hBB);
    bus.i_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    send(8'hCC);
    chk("race_no_flush", {63'd0, bus.o_valid}, 64'd0);
    send(8'hDD);
    bus.i_valid = 1'b0;
    chk("race_word_valid", {63'd0, bus.o_valid}, 64'd1);
    wait_drain();

    // Blocked flush: partial word waits behind a stalled full word
    push(32'h13121110, 4'hF);
    push(32'h00000020, 4'h1);
    bus.i_ready = 1'b0;
    send(8'h10);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    send(8'h20);
    bus.i_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("blocked_held", {32'd0, bus.o_data}, 64'h13121110);
    chk("blocked_keep", {60'd0, bus.o_keep}, 64'hF);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("blocked_flush_valid", {63'd0, bus.o_valid}, 64'd1);
    chk("blocked_flush_data",  {32'd0, bus.o_data}, 64'h00000020);
    chk("blocked_flush_keep",  {60'd0, bus.o_keep}, 64'h1);
    wait_drain();

    // Reset mid-word discards the partial word
    send(8'h50);
    send(8'h51);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, bus.o_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.o_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(32'h63626160, 4'hF);
    send(8'h60);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    bus.i_valid = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_packer.md
# stream_packer

Single-clock packer that sits directly downstream of the dual-clock FIFO's read port. It accepts DATA_WIDTH-bit beats over a valid-ready handshake and assembles RATIO beats into one wide word. It presents each word on a registered valid-ready output with a per-lane keep mask. An idle timeout flushes a partially filled word so that trailing beats are never stranded.

## Interface
- DATA_WIDTH, 8, width of one input beat (lane)
- RATIO, 4, beats per output word; legal range >= 2
- TIMEOUT, 16, idle cycles before a partial word is flushed; 0 disables flushing
- i_clk  input  1  clock; all logic on the rising edge
- i_rst  input  1  reset, asynchronous assert, active-low
- i_valid  input  1  input beat valid
- o_ready  output  1  input beat accepted when i_valid && o_ready
- i_data  input  DATA_WIDTH  input beat
- o_valid  output  1  output word valid
- i_ready  input  1  downstream ready; a word transfers when o_valid && i_ready
- o_data  output  DATA_WIDTH*RATIO  packed word; the first beat is in lane 0 (LSBs)
- o_keep  output  RATIO  one bit per lane; 1 = lane holds a real beat

## Operation
- State:
  - accumulator acc[DATA_WIDTH*RATIO-1:0]
  - lane count cnt, range 0..RATIO-1
  - idle counter idle, width clog2(TIMEOUT+1), saturating at TIMEOUT
  - output register out_data/out_keep/out_valid
- out_free = !o_valid || i_ready.
- o_ready:
  - equals (cnt != RATIO-1) || out_free; this is combinational from i_ready.
  - forced to 0 while i_rst is low.
- Accepted beat with cnt < RATIO-1:
  - writes lane cnt of acc
  - cnt <= cnt+1
  - idle <= 0
- Accepted beat with cnt == RATIO-1 (completing beat):
  - out_data <= acc with lane RATIO-1 replaced by i_data
  - out_keep <= all ones
  - out_valid <= 1
  - acc <= 0, cnt <= 0, idle <= 0
- Output drain: o_valid && i_ready with no new load clears out_valid. A load and a drain in the same cycle keeps out_valid at 1 with the new word.
- Idle counting: when cnt > 0, no beat is accepted this cycle, and TIMEOUT != 0, idle increments and saturates at TIMEOUT.
- Flush:
  - Condition: TIMEOUT != 0, cnt > 0, idle == TIMEOUT, out_free, and no beat accepted this cycle.
  - Action: out_data <= acc (unfilled lanes zero), out_keep <= mask with bits [cnt-1:0] set, out_valid <= 1, acc <= 0, cnt <= 0, idle <= 0.
- Flush blocked by a full output: idle stays saturated and the flush fires on the first cycle out_free is true.
- A beat accepted in the same cycle as a flush condition wins:
  - The beat is packed and idle is cleared.
  - No flush occurs that cycle.
  - If that beat completes the word, the normal completing path is taken.
- cnt == 0 holds idle at 0; an empty accumulator is never flushed.
- Output stability: o_data and o_keep hold constant while o_valid && !i_ready.
- Beat ordering is preserved; no beat is dropped or duplicated.

## Timing
- Reset values (async, while i_rst low):
  - o_valid = 0, o_data = 0, o_keep = 0, o_ready = 0
  - acc = 0, cnt = 0, idle = 0
- After reset release, o_ready = 1 on the first cycle.
- Latency: a completing beat accepted at edge N gives o_valid = 1 after edge N, visible in cycle N+1.
- Flush latency: with the output free, the last accepted beat at edge N flushes at edge N+TIMEOUT+1.
- Throughput: 1 beat/cycle sustained while i_ready stays high; no bubble between words.
- Backpressure:
  - With i_ready low and o_valid high, the block accepts RATIO-1 further beats.
  - o_ready then drops until i_ready rises.
  - Beats accepted: at most RATIO-1 while the output is stalled.
- Reset mid-operation discards any partial word and any pending output word immediately.

## Test plan
- Streaming (RATIO=4): bytes 0x11,0x22,0x33,0x44,0x55..0x88 on consecutive cycles, i_ready=1 -> o_data=0x44332211 and then 0x88776655 on consecutive cycles, o_keep=4'b1111, o_ready always 1.
- Backpressure: i_ready=0, 12 beats offered back-to-back -> first word held stable, exactly 3 more beats accepted, o_ready=0. i_ready=1 -> words drain in order with no loss.
- Timeout flush (TIMEOUT=16): beats 0xAA,0xBB then idle -> o_valid=1 exactly 17 cycles after the 0xBB handshake, o_data=0x0000BBAA, o_keep=4'b0011.
- Flush vs arrival: beat 0xCC offered on the cycle idle reaches 16 -> no flush; cnt advances to 3. A fourth beat 0xDD completes the word -> o_data=0xDDCCBBAA, o_keep=4'b1111.
- Blocked flush: partial word with 1 beat, output full and i_ready=0 for 40 cycles -> no flush. i_ready=1 -> held word drains, then the flush word appears the next cycle with o_keep=4'b0001.
- Reset mid-word: 2 beats accepted, then i_rst pulsed low -> o_valid=0 and o_ready=0 during reset. Next 4 beats form a full word with no stale lanes.
